branch_pc_unit: RTL

Program-counter and branch-resolution stage sitting directly downstream of the branch comparator in the EX stage. Drives the comparator's `BrUn` select, consumes its `BrEq`/`BrLT` results, decides taken/not-taken for conditional branches and JAL/JALR, holds the fetch PC register, and squashes wrong-path instructions with a timed flush. Misaligned redirect targets raise a held trap until acknowledged.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/branch_cond.sv | 26 ++
 rtl/branch_pc_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared constants and types for the EX-stage branch/PC unit.
package branch_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode: maps funct3 and comparator flags to taken, and selects unsigned compare.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       cond_c,
  output logic       br_un_c
);

  always_comb begin
    cond_c = 1'b0;
    case (funct3)
      F3_BEQ:           cond_c = br_eq;
      F3_BNE:           cond_c = ~br_eq;
      F3_BLT, F3_BLTU:  cond_c = br_lt;
      F3_BGE, F3_BGEU:  cond_c = ~br_lt;
      default:          cond_c = 1'b0;
    endcase
  end

  // Unsigned variants (BLTU/BGEU) are the only ones with funct3[1] set among real branches.
  assign br_un_c = funct3[1];

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC register with branch/jump resolution, timed wrong-path flush and misaligned-target trap.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0004,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        BrUn,
  output logic [31:0] pc,
  output logic        redirect,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_addr,
  input  logic        trap_ack
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   trap_addr_q, trap_addr_d;
  logic              flush_q, flush_d;
  logic              trap_q, trap_d;

  logic              cond;
  logic              take;
  logic              misaligned;
  logic [PC_W-1:0]   jalr_tgt;
  logic [PC_W-1:0]   rel_tgt;
  logic [PC_W-1:0]   target;

  branch_cond u_cond (
    .funct3  (ex_funct3),
    .br_eq   (BrEq),
    .br_lt   (BrLT),
    .cond_c  (cond),
    .br_un_c (BrUn)
  );

  // Target adders; JALR clears bit 0 so only bit 1 can make it misaligned.
  always_comb begin
    jalr_tgt   = (ex_rs1 + ex_imm) & ~32'h1;
    rel_tgt    = ex_pc + ex_imm;
    target     = ex_jalr ? jalr_tgt : rel_tgt;
    misaligned = ex_jalr ? target[1] : (|target[1:0]);
    take       = ex_valid & (ex_jalr | ex_jal | (ex_branch & cond));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    trap_addr_d = trap_addr_q;
    redirect    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (take && !misaligned) begin
          redirect = 1'b1;
          pc_d     = target;
          cnt_d    = CNT_W'(FLUSH_CYCLES);
          state_d  = ST_FLUSH;
        end else if (take) begin
          trap_addr_d = target;
          state_d     = ST_TRAP;
        end else if (!stall) begin
          pc_d = pc_q + PC_INC;
        end
      end
      ST_FLUSH: begin
        // Wrong-path instructions in EX are ignored; only the counter drives the exit.
        if (!stall) begin
          pc_d  = pc_q + PC_INC;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_TRAP: begin
        if (trap_ack) begin
          pc_d    = TRAP_VEC;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    flush_d = (state_d != ST_RUN);
    trap_d  = (state_d == ST_TRAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pc_q        <= RESET_PC;
      trap_addr_q <= '0;
      flush_q     <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      trap_addr_q <= trap_addr_d;
      flush_q     <= flush_d;
      trap_q      <= trap_d;
    end
  end

  assign pc        = pc_q;
  assign flush     = flush_q;
  assign trap      = trap_q;
  assign trap_addr = trap_addr_q;

endmodule
